branch_resolve_unit: RTL

- Parametrised branch/jump resolution stage placed between decode/register-read and writeback/fetch-redirect.
- Evaluates all RV32 conditional branches plus JAL/JALR, computes the target and link address, and compares the outcome against the fetch-stage prediction.
- Owns a 2-bit saturating branch history table (BHT) that fetch queries and resolution trains.
- Output is a registered valid/ready stage with flush support.

---
 rtl/branch_resolve_unit_pkg.sv | 32 +++
 rtl/branch_bht.sv | 38 +++
 rtl/branch_resolve_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolution stage.
//   op_e       : resolution op (cond branch, JAL, JALR, reserved)
//   F3_*       : RV32 conditional-branch funct3 values
//   SNT..ST    : 2-bit saturating counter states
//   sat_update : one training step of a 2-bit counter
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    OP_BR   = 2'b00,
    OP_JAL  = 2'b01,
    OP_JALR = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: array of 2-bit saturating counters.
//   i_upd_en/i_upd_idx/i_upd_taken : train one counter on the clock edge
//   i_lkp_idx                      : fetch query index
//   o_lkp_taken                    : registered MSB of the queried counter
// The lookup samples the counter before the same-edge update lands, so a
// colliding lookup returns the pre-update value.
module branch_bht
  import branch_resolve_unit_pkg::*;
#(
  parameter int         ENTRIES = 16,
  parameter int         IDX_W   = $clog2(ENTRIES),
  parameter logic [1:0] RESET   = WNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic [IDX_W-1:0] i_lkp_idx,
  output logic             o_lkp_taken
);

  logic [ENTRIES-1:0][1:0] r_ctr;
  logic                    r_lkp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= {ENTRIES{RESET}};
      r_lkp <= 1'b0;
    end else begin
      r_lkp <= r_ctr[i_lkp_idx][1];
      if (i_upd_en) r_ctr[i_upd_idx] <= sat_update(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

  assign o_lkp_taken = r_lkp;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage with a 1-deep registered valid/ready output.
//   in_*      : resolution request (op, funct3, operands, pc, fetch prediction)
//   out_*     : registered result: direction, target, link, mispredict,
//               redirect pc, illegal flag
//   flush_i   : drops the held result and any request accepted this cycle
//   lookup_*  : fetch-side BHT query, answered one cycle later
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 16,
  parameter int         IMM_SHIFT   = 2,
  parameter logic [1:0] BHT_RESET   = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      op_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic [XLEN-1:0] link_o,
  output logic            mispredict_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_o,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            lookup_taken_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            w_eq, w_lt, w_ltu, w_cond, w_illegal, w_taken, w_misp;
  logic            w_accept, w_load, w_upd;
  logic [XLEN-1:0] w_pcrel_tgt, w_jalr_tgt, w_target, w_link, w_redirect;
  logic            w_unused;

  assign w_eq  = (rs1_i == rs2_i);
  assign w_lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign w_ltu = (rs1_i < rs2_i);

  always_comb begin
    w_cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt;
      F3_BGE:  w_cond = !w_lt;
      F3_BLTU: w_cond = w_ltu;
      F3_BGEU: w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  // funct3 only carries a condition for conditional branches, so the
  // reserved 010/011 codes are illegal only there.
  assign w_illegal = (op_i == OP_ILL) ||
                     ((op_i == OP_BR) && (funct3_i == 3'b010 || funct3_i == 3'b011));

  assign w_taken     = !w_illegal && ((op_i == OP_BR) ? w_cond : 1'b1);
  assign w_pcrel_tgt = pc_i + (imm_i << IMM_SHIFT);
  assign w_jalr_tgt  = (rs1_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
  assign w_target    = (op_i == OP_JALR) ? w_jalr_tgt : w_pcrel_tgt;
  assign w_link      = pc_i + XLEN'(4);
  assign w_redirect  = w_taken ? w_target : w_link;
  // Illegal ops resolve not-taken, so this reduces to pred_taken_i for them.
  assign w_misp      = (w_taken != pred_taken_i) || (w_taken && (w_target != pred_target_i));

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_load     = w_accept && !flush_i;
  assign w_upd      = w_load && (op_i == OP_BR) && !w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o   <= 1'b0;
      taken_o       <= 1'b0;
      target_o      <= '0;
      link_o        <= '0;
      mispredict_o  <= 1'b0;
      redirect_pc_o <= '0;
      illegal_o     <= 1'b0;
    end else begin
      if (w_load) begin
        out_valid_o   <= 1'b1;
        taken_o       <= w_taken;
        target_o      <= w_target;
        link_o        <= w_link;
        mispredict_o  <= w_misp;
        redirect_pc_o <= w_redirect;
        illegal_o     <= w_illegal;
      end else if (flush_i || out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  branch_bht #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W),
    .RESET   (BHT_RESET)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_upd_en    (w_upd),
    .i_upd_idx   (pc_i[IMM_SHIFT +: IDX_W]),
    .i_upd_taken (w_taken),
    .i_lkp_idx   (lookup_pc_i[IMM_SHIFT +: IDX_W]),
    .o_lkp_taken (lookup_taken_o)
  );

  // Only the index bits of the lookup pc matter.
  assign w_unused = ^lookup_pc_i;

endmodule
